// File: rtl/score_display.sv
// Purpose : 11-bit binary score -> 4 BCD digits (sequential double-dabble),
//           time-multiplexed onto a 4-digit common-anode 7-segment display.
// Latency : bcd valid 12 edges after the IDLE sample; one conversion every 13 cycles.
// Backpressure: none; converts continuously, score changes wait for the next IDLE sample.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   score  - binary score 0..2047
//   bcd    - {thousands, hundreds, tens, units}, updated atomically on LOAD
//   seg    - active-low segments {g,f,e,d,c,b,a}, registered
//   dp     - active-low decimal point, held off (1)
//   an     - active-low one-hot digit enables, an[0] = units, registered
module score_display #(
  parameter int DIGIT_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] score,
  output logic [15:0] bcd,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [10:0] shift_reg;
  logic [15:0] scratch;
  logic [3:0]  iter;
  logic        last_iter;

  logic [15:0] scratch_adj;
  logic [15:0] scratch_nxt;
  logic [10:0] shift_nxt;

  // iter counts completed SHIFT cycles; the 11th SHIFT sees iter == 10.
  assign last_iter = (iter == 4'd10);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   state_nxt = last_iter ? LOAD : SHIFT;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, applied before the shift so the
  // doubling that follows carries correctly into the next decimal digit.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // {scratch, shift_reg} shifted left by one as a single 27-bit register.
  assign scratch_nxt = {scratch_adj[14:0], shift_reg[10]};
  assign shift_nxt   = {shift_reg[9:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          shift_reg <= score;
          scratch   <= '0;
          iter      <= '0;
        end
        SHIFT: begin
          shift_reg <= shift_nxt;
          scratch   <= scratch_nxt;
          iter      <= iter + 4'd1;
        end
        LOAD: begin
          // Only place bcd is written, so all four digits change together.
          bcd <= scratch;
        end
        default: begin
          shift_reg <= shift_reg;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic             scan_wrap;
  logic [1:0]       digit_idx;
  logic [1:0]       digit_idx_nxt;

  assign scan_wrap     = (scan_cnt == CNT_W'(DIGIT_PERIOD - 1));
  assign digit_idx_nxt = scan_wrap ? digit_idx + 2'd1 : digit_idx;

  // seg/an are computed from the index the register is about to hold, so the
  // anode and its segment pattern switch on the same edge (no ghost cycle).
  logic [3:0] digit_nib;
  logic       digit_blank;
  logic [6:0] digit_seg;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  always_comb begin
    digit_nib   = bcd[3:0];
    digit_blank = 1'b0;
    case (digit_idx_nxt)
      2'd0: begin
        digit_nib   = bcd[3:0];
        digit_blank = 1'b0;               // units always shown
      end
      2'd1: begin
        digit_nib   = bcd[7:4];
        digit_blank = (bcd[15:4] == 12'h000);
      end
      2'd2: begin
        digit_nib   = bcd[11:8];
        digit_blank = (bcd[15:8] == 8'h00);
      end
      default: begin
        digit_nib   = bcd[15:12];
        digit_blank = (bcd[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    digit_seg = 7'h7F;
    case (digit_nib)
      4'd0:    digit_seg = 7'h40;
      4'd1:    digit_seg = 7'h79;
      4'd2:    digit_seg = 7'h24;
      4'd3:    digit_seg = 7'h30;
      4'd4:    digit_seg = 7'h19;
      4'd5:    digit_seg = 7'h12;
      4'd6:    digit_seg = 7'h02;
      4'd7:    digit_seg = 7'h78;
      4'd8:    digit_seg = 7'h00;
      4'd9:    digit_seg = 7'h10;
      default: digit_seg = 7'h7F;       // non-decimal nibble: dark
    endcase
  end

  assign seg_nxt = digit_blank ? 7'h7F : digit_seg;
  assign an_nxt  = ~(4'b0001 << digit_idx_nxt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= 7'h40;
      dp        <= 1'b1;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
      digit_idx <= digit_idx_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] score = '0;
  logic [15:0] bcd;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 clk = ~clk;

  score_display #(.DIGIT_PERIOD(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .score (score),
    .bcd   (bcd),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference: digits of v packed as nibbles.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // What digit position i of value v must show, leading zeros blanked.
  function automatic logic [6:0] digit_seg(input int v, input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (i > 0 && v < p) return 7'h7F;
    case ((v / p) % 10)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Behavioural model: k = rising edges since the last reset edge.
  // Samples happen on edges 1, 14, 27, ...; results appear on edges 13, 26, ...
  int         k = 0;
  int         sampled = 0;
  int         m_val = 0;
  int         prev_val = 0;
  logic [6:0] m_seg = 7'h40;
  logic [3:0] m_an = 4'b1110;
  logic [3:0] one4 = 4'b0001;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      k     = 0;
      m_val = 0;
      m_seg = 7'h40;
      m_an  = 4'b1110;
    end else begin
      prev_val = m_val;
      k = k + 1;
      if ((k - 1) % 13 == 0) sampled = score;
      if (k % 13 == 0) m_val = sampled;
      m_an  = ~(one4 << ((k / DP) % 4));
      m_seg = digit_seg(prev_val, (k / DP) % 4);
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("bcd_model", 32'(bcd), 32'(to_bcd(m_val)));
      check("an_model",  32'(an),  32'(m_an));
      check("seg_model", 32'(seg), 32'(m_seg));
      check("dp_model",  32'(dp),  32'd1);
    end
  end

  // Align to the start of a frame, then check 4 digits x DP cycles each.
  task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] seg_tab [4];
    logic [3:0] an_tab [4];
    int n = 0;
    seg_tab = '{s0, s1, s2, s3};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do begin
      @(negedge clk);
      n++;
    end while (k % (4 * DP) != 0 && n < 40);
    check({tag, "_align"}, 32'(k % (4 * DP)), 32'd0);
    for (int j = 0; j < 4 * DP; j++) begin
      check({tag, "_an"},  32'(an),  32'(an_tab[j / DP]));
      check({tag, "_seg"}, 32'(seg), 32'(seg_tab[j / DP]));
      @(negedge clk);
    end
  endtask

  task automatic align13();
    int n = 0;
    while (k % 13 != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [15:0] seen [$];
  logic [15:0] last;
  int          hit;

  initial begin
    // Reset held for 3 edges
    reset = 1'b0;
    score = 11'd1234;
    repeat (3) begin
      @(negedge clk);
      check("rst_an",  32'(an),  32'h0000000E);
      check("rst_seg", 32'(seg), 32'h00000040);
      check("rst_dp",  32'(dp),  32'd1);
      check("rst_bcd", 32'(bcd), 32'h00000000);
    end
    reset = 1'b1;

    // 1234: still zero after 12 edges, converted after 13
    @(negedge clk);
    check("post_rst_an",  32'(an),  32'h0000000E);
    check("post_rst_seg", 32'(seg), 32'h00000040);
    repeat (11) @(negedge clk);
    check("pre_load_bcd", 32'(bcd), 32'h00000000);
    @(negedge clk);
    check("bcd_1234", 32'(bcd), 32'h00001234);

    // 2047: no blanking
    score = 11'd2047;
    repeat (27) @(negedge clk);
    check("bcd_2047", 32'(bcd), 32'h00002047);
    scan_check("scan2047", 7'h78, 7'h19, 7'h40, 7'h24);

    // 7: upper three digits blank
    score = 11'd7;
    repeat (27) @(negedge clk);
    check("bcd_7", 32'(bcd), 32'h00000007);
    scan_check("scan7", 7'h78, 7'h7F, 7'h7F, 7'h7F);

    // 10: zero in units shown, upper two blank
    score = 11'd10;
    repeat (27) @(negedge clk);
    check("bcd_10", 32'(bcd), 32'h00000010);
    scan_check("scan10", 7'h40, 7'h79, 7'h7F, 7'h7F);

    // 5 sampled, then 999 mid-SHIFT
    align13();
    score = 11'd5;
    repeat (5) @(negedge clk);
    score = 11'd999;
    last = bcd;
    hit = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bcd !== last) begin
        seen.push_back(bcd);
        last = bcd;
        if (bcd == 16'h0999 && hit < 0) hit = c;
      end
    end
    check("toggle_nchanges", 32'(seen.size()), 32'd2);
    check("toggle_first",  32'((seen.size() > 0) ? seen[0] : 16'hFFFF), 32'h00000005);
    check("toggle_second", 32'((seen.size() > 1) ? seen[1] : 16'hFFFF), 32'h00000999);
    check("toggle_latency_ok", 32'(hit >= 1 && hit <= 26), 32'd1);

    // Reset mid-conversion
    score = 11'd321;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_bcd", 32'(bcd), 32'h00000000);
    check("midrst_an",  32'(an),  32'h0000000E);
    check("midrst_seg", 32'(seg), 32'h00000040);
    reset = 1'b1;
    repeat (13) @(negedge clk);
    check("midrst_bcd_321", 32'(bcd), 32'h00000321);

    // Full sweep, one conversion per value
    align13();
    for (int v = 0; v < 2048; v++) begin
      score = 11'(v);
      repeat (13) @(negedge clk);
      check("sweep_bcd", 32'(bcd), 32'(to_bcd(v)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the game's `score_out` bus: converts the 11-bit binary score to four BCD digits with a sequential double-dabble engine and time-multiplexes them onto the board's 4-digit common-anode seven-segment display. It sits beside `graphic` in the top level, fed directly by `score`, and owns the `seg`/`an`/`dp` board pins. Leading zeros are blanked; the units digit is always shown.

## Interface
- `DIGIT_PERIOD`, 100000, clk cycles each digit is driven (1 kHz/digit at 100 MHz); must be ≥ 2
- `clk` in 1 system clock; all logic on its rising edge
- `reset` in 1 synchronous, active-low reset: `reset`=0 at a rising edge resets the block
- `score` in 11 binary score, 0..2047, sampled asynchronously to game events
- `bcd` out 16 converted digits {thousands, hundreds, tens, units}, 4 bits each; verification/observability port
- `seg` out 7 active-low segments {g,f,e,d,c,b,a}
- `dp` out 1 decimal point, active-low; constant 1
- `an` out 4 active-low digit enables, one-hot-low; `an[0]` = units

## Operation
- Conversion FSM states: IDLE, SHIFT, LOAD.
  - IDLE: latch `score` into an 11-bit shift register, clear the 16-bit BCD scratch, clear the iteration counter; go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left by 1; after the 11th iteration go to LOAD.
  - LOAD: copy scratch to `bcd` in one cycle, so all four digits update atomically; go to IDLE.
- Conversion runs continuously, with no handshake. Changes to `score` during SHIFT/LOAD are ignored until the next IDLE sample.
- Scan counter: counts 0..DIGIT_PERIOD-1 and wraps. On wrap, digit index 0→1→2→3→0 advances.
- Digit index i drives `an` = ~(1<<i) and the segments of `bcd[4i+3:4i]`.
- Blanking: digit i>0 is blank when it and all higher digits are 0. A blank digit drives `seg`=7'h7F, with its `an` still active.
- Segment codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles >9 cannot occur; drive 7'h7F if one does.

## Timing
- Reset values:
  - FSM: IDLE
  - `bcd` = 16'h0000
  - scan counter 0, digit index 0
  - `an` = 4'b1110
  - `seg` = 7'h40
  - `dp` = 1
- Conversion latency: `score` sampled in IDLE at edge N; `bcd` valid after edge N+12 (1 IDLE + 11 SHIFT + 1 LOAD cycle; 13-cycle period).
- Worst-case update after a `score` change: 26 cycles, if the change lands just after a sample.
- `seg`, `an` and `dp` are registered.
  - `an` and `seg` change on the same edge the digit index advances, so no cross-digit ghost cycle.
  - `seg` also follows `bcd` of the current digit one cycle after a LOAD.
- Each digit is active exactly DIGIT_PERIOD cycles; full frame is 4·DIGIT_PERIOD cycles.
- Reset mid-conversion aborts it: the next cycle is IDLE, `bcd` = 0, and the display restarts at digit 0.
- Reset has priority over all other activity on the same edge.
- Boundary values: `score`=0 shows only "0". `score`=2047 shows "2047", with no blanking.

## Test plan
- Reset with `reset`=0 for 3 cycles, then release. Required: `an`=1110, `seg`=40, `dp`=1, `bcd`=0000 before and after release until the first LOAD.
- `score`=1234 held. Required: `bcd`=16'h1234 within 13 cycles after reset release.
- `score`=2047 held, DIGIT_PERIOD=4. Required:
  - `bcd`=16'h2047
  - (`an`,`seg`) sequence is (1110,78), (1101,19), (1011,40), (0111,24), each held exactly 4 cycles, repeating.
- `score`=7, DIGIT_PERIOD=4. Required: digit 0 `seg`=78; digits 1–3 `seg`=7F with their `an` low. Then `score`=10: digit 1 `seg`=79, digit 0 `seg`=40, digits 2–3 blank.
- `score` toggled 5→999 in the middle of SHIFT. Required:
  - `bcd` first becomes 0005, then 0999 no later than 26 cycles after the change
  - no intermediate value appears on `bcd`.
- Sweep all 2048 `score` values. Required: `bcd` matches the decimal reference for each, checked after each LOAD.
